// File: rtl/regional_max.sv
// 8-connected regional-maximum mask of an MxN grey image.
// A SEEK pass clears pixels that have a strictly greater neighbour; PROP passes then spread those clears across equal-valued plateaus.
module regional_max #(
  parameter int M            = 8,
  parameter int N            = 8,
  parameter int PIXEL_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 3,
  parameter int I_WIDTH      = 3,
  parameter int J_WIDTH      = 3,
  parameter int ADDR_WIDTH   = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   write_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic                   start,
  output logic                   done,
  output logic [M-1:0][N-1:0]    matrix_output
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_SEEK, S_PROP, S_DONE} state_t;

  localparam logic [I_WIDTH:0]   M_EXT  = (I_WIDTH+1)'(M);
  localparam logic [J_WIDTH:0]   N_EXT  = (J_WIDTH+1)'(N);
  localparam logic [I_WIDTH:0]   ONE_I  = (I_WIDTH+1)'(1);
  localparam logic [J_WIDTH:0]   ONE_J  = (J_WIDTH+1)'(1);
  localparam logic [I_WIDTH-1:0] LAST_I = I_WIDTH'(M-1);
  localparam logic [J_WIDTH-1:0] LAST_J = J_WIDTH'(N-1);
  localparam logic [1:0]         LAST_K = 2'(WINDOW_WIDTH-1);

  state_t                 state_q, state_d;
  logic [I_WIDTH-1:0]     i_q, i_d;
  logic [J_WIDTH-1:0]     j_q, j_d;
  logic [1:0]             kr_q, kr_d, kc_q, kc_d;
  logic                   changed_q, changed_d;
  logic                   done_q, done_d;
  logic [M-1:0][N-1:0]    flag_q, flag_d;
  logic [M-1:0][N-1:0]    mask_q, mask_d;

  logic [PIXEL_WIDTH-1:0] img_mem [M][N];

  logic                   unused_rd;
  assign unused_rd = ^rd_addr;

  // Image RAM: loaded only while not computing, never reset
  logic [I_WIDTH-1:0] wr_i;
  logic [J_WIDTH-1:0] wr_j;
  logic               host_phase;
  assign wr_i       = wr_addr[ADDR_WIDTH-1:J_WIDTH];
  assign wr_j       = wr_addr[J_WIDTH-1:0];
  assign host_phase = (state_q == S_IDLE) || (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (write_en && host_phase && ({1'b0, wr_i} < M_EXT) && ({1'b0, wr_j} < N_EXT)) begin
      img_mem[wr_i][wr_j] <= pixel_in;
    end
  end

  // Current neighbour of the window; wrap-around below zero lands out of range
  logic [I_WIDTH:0]       ni_ext;
  logic [J_WIDTH:0]       nj_ext;
  logic [I_WIDTH-1:0]     ni;
  logic [J_WIDTH-1:0]     nj;
  logic                   nb_valid;
  logic [PIXEL_WIDTH-1:0] ctr_pix, nb_pix;
  logic                   ctr_flag, nb_flag;
  logic                   last_step;

  assign ni_ext    = {1'b0, i_q} + {{(I_WIDTH-1){1'b0}}, kr_q} - ONE_I;
  assign nj_ext    = {1'b0, j_q} + {{(J_WIDTH-1){1'b0}}, kc_q} - ONE_J;
  assign ni        = ni_ext[I_WIDTH-1:0];
  assign nj        = nj_ext[J_WIDTH-1:0];
  assign nb_valid  = (ni_ext < M_EXT) && (nj_ext < N_EXT) && !((kr_q == 2'd1) && (kc_q == 2'd1));
  assign ctr_pix   = img_mem[i_q][j_q];
  assign nb_pix    = img_mem[ni][nj];
  assign ctr_flag  = flag_q[i_q][j_q];
  assign nb_flag   = flag_q[ni][nj];
  assign last_step = (kr_q == LAST_K) && (kc_q == LAST_K) && (i_q == LAST_I) && (j_q == LAST_J);

  always_comb begin
    logic clear;
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    kr_d      = kr_q;
    kc_d      = kc_q;
    changed_d = changed_q;
    done_d    = done_q;
    flag_d    = flag_q;
    mask_d    = mask_q;
    clear     = 1'b0;

    // Raster walk: window column, window row, pixel column, pixel row
    if ((state_q == S_SEEK) || (state_q == S_PROP)) begin
      if (kc_q == LAST_K) begin
        kc_d = 2'd0;
        if (kr_q == LAST_K) begin
          kr_d = 2'd0;
          if (j_q == LAST_J) begin
            j_d = '0;
            i_d = (i_q == LAST_I) ? '0 : i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          kr_d = kr_q + 2'd1;
        end
      end else begin
        kc_d = kc_q + 2'd1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d  = 1'b0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        flag_d  = '1;
        i_d     = '0;
        j_d     = '0;
        kr_d    = 2'd0;
        kc_d    = 2'd0;
        state_d = S_SEEK;
      end
      S_SEEK: begin
        if (nb_valid && (nb_pix > ctr_pix)) begin
          flag_d[i_q][j_q] = 1'b0;
        end
        if (last_step) begin
          changed_d = 1'b0;
          state_d   = S_PROP;
        end
      end
      S_PROP: begin
        clear     = ctr_flag && nb_valid && (nb_pix == ctr_pix) && !nb_flag;
        if (clear) begin
          flag_d[i_q][j_q] = 1'b0;
        end
        changed_d = changed_q | clear;
        if (last_step) begin
          if (changed_q || clear) begin
            changed_d = 1'b0;
          end else begin
            mask_d  = flag_q;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      kr_q      <= 2'd0;
      kc_q      <= 2'd0;
      changed_q <= 1'b0;
      done_q    <= 1'b0;
      flag_q    <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      kr_q      <= kr_d;
      kc_q      <= kc_d;
      changed_q <= changed_d;
      done_q    <= done_d;
      flag_q    <= flag_d;
      mask_q    <= mask_d;
    end
  end

  assign done          = done_q;
  assign matrix_output = mask_q;

endmodule

// File: tb/tb_regional_max.sv
// Directed bench for regional_max: loads small images, runs the search, compares the mask to hand-derived values.
module tb_regional_max;

  localparam int LIMIT = 20000;
  localparam logic [63:0] MASK_PEAK     = 64'h0000_0000_0400_0000; // bit [3][2]
  localparam logic [63:0] MASK_PLATEAU  = 64'h0000_0000_0006_0600; // [1][1],[1][2],[2][1],[2][2]
  localparam logic [63:0] MASK_DOMINATE = 64'h0000_0000_0800_0000; // bit [3][3]
  localparam logic [63:0] MASK_ONES     = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MASK_CORNERS  = 64'h8000_0000_0000_0001; // [7][7] and [0][0]

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             write_en = 1'b0;
  logic [5:0]       wr_addr = 6'd0;
  logic [7:0]       pixel_in = 8'd0;
  logic [5:0]       rd_addr = 6'd0;
  logic             start = 1'b0;
  logic             done;
  logic [7:0][7:0]  matrix_output;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regional_max dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .write_en      (write_en),
    .wr_addr       (wr_addr),
    .pixel_in      (pixel_in),
    .rd_addr       (rd_addr),
    .start         (start),
    .done          (done),
    .matrix_output (matrix_output)
  );

  task automatic write_px(input int i, input int j, input logic [7:0] v);
    write_en = 1'b1;
    wr_addr  = 6'(i * 8 + j);
    pixel_in = v;
    @(posedge clk); #1;
    write_en = 1'b0;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        write_px(i, j, v);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int cycles);
    cycles = 0;
    while (!done && cycles < LIMIT) begin
      @(posedge clk); #1;
      cycles++;
    end
    ok = done;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if (matrix_output !== 64'd0) begin errors++; $display("FAIL reset_mask got %h want 0", matrix_output); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    $display("reset released done=%b mask=%h", done, matrix_output);
  endtask

  task automatic test_single_peak;
    bit ok; int cyc;
    fill(8'd0);
    write_px(3, 2, 8'd9);
    pulse_start();
    wait_done(ok, cyc);
    checks++;
    if (!ok || cyc > 3000) begin errors++; $display("FAIL peak_latency got ok=%b cycles=%0d want done within 3000", ok, cyc); end
    checks++;
    if (matrix_output !== MASK_PEAK) begin errors++; $display("FAIL peak_mask got %h want %h", matrix_output, MASK_PEAK); end
    $display("single_peak cycles=%0d mask=%h", cyc, matrix_output);
  endtask

  task automatic test_plateau;
    bit ok; int cyc;
    fill(8'd0);
    write_px(1, 1, 8'd5); write_px(1, 2, 8'd5);
    write_px(2, 1, 8'd5); write_px(2, 2, 8'd5);
    pulse_start();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL start_clears_done got %b want 0", done); end
    wait_done(ok, cyc);
    checks++;
    if (!ok) begin errors++; $display("FAIL plateau_timeout got done=0 want 1"); end
    checks++;
    if (matrix_output !== MASK_PLATEAU) begin errors++; $display("FAIL plateau_mask got %h want %h", matrix_output, MASK_PLATEAU); end
    $display("plateau cycles=%0d mask=%h", cyc, matrix_output);
  endtask

  task automatic test_plateau_dominated;
    bit ok; int cyc;
    write_px(3, 3, 8'd7);
    pulse_start();
    wait_done(ok, cyc);
    checks++;
    if (!ok) begin errors++; $display("FAIL dominated_timeout got done=0 want 1"); end
    checks++;
    if (matrix_output !== MASK_DOMINATE) begin errors++; $display("FAIL dominated_mask got %h want %h", matrix_output, MASK_DOMINATE); end
    $display("plateau_dominated cycles=%0d mask=%h", cyc, matrix_output);
  endtask

  task automatic test_constant;
    bit ok; int cyc;
    fill(8'd4);
    pulse_start();
    wait_done(ok, cyc);
    checks++;
    if (matrix_output !== MASK_ONES) begin errors++; $display("FAIL constant_mask got %h want %h", matrix_output, MASK_ONES); end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || matrix_output !== MASK_ONES) begin
        errors++;
        $display("FAIL constant_hold cycle %0d got done=%b mask=%h want 1 %h", c, done, matrix_output, MASK_ONES);
      end
    end
    $display("constant cycles=%0d mask=%h", cyc, matrix_output);
  endtask

  task automatic test_corners;
    bit ok; int cyc;
    fill(8'd1);
    write_px(0, 0, 8'd200);
    write_px(7, 7, 8'd200);
    pulse_start();
    wait_done(ok, cyc);
    checks++;
    if (!ok) begin errors++; $display("FAIL corners_timeout got done=0 want 1"); end
    checks++;
    if (matrix_output !== MASK_CORNERS) begin errors++; $display("FAIL corners_mask got %h want %h", matrix_output, MASK_CORNERS); end
    $display("corners cycles=%0d mask=%h", cyc, matrix_output);
  endtask

  task automatic test_busy_write;
    bit ok; int cyc;
    fill(8'd0);
    write_px(3, 2, 8'd9);
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    write_px(5, 5, 8'd50);
    wait_done(ok, cyc);
    checks++;
    if (matrix_output !== MASK_PEAK) begin errors++; $display("FAIL busy_write_run1 got %h want %h", matrix_output, MASK_PEAK); end
    pulse_start();
    wait_done(ok, cyc);
    checks++;
    if (!ok || matrix_output !== MASK_PEAK) begin
      errors++;
      $display("FAIL busy_write_run2 got done=%b mask=%h want 1 %h", ok, matrix_output, MASK_PEAK);
    end
    $display("busy_write mask=%h", matrix_output);
  endtask

  task automatic test_reset_midrun;
    bit ok; int cyc;
    pulse_start();
    repeat (100) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL midrun_reset_done got %b want 0", done); end
    checks++;
    if (matrix_output !== 64'd0) begin errors++; $display("FAIL midrun_reset_mask got %h want 0", matrix_output); end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    wait_done(ok, cyc);
    checks++;
    if (!ok) begin errors++; $display("FAIL rerun_timeout got done=0 want 1"); end
    checks++;
    if (matrix_output !== MASK_PEAK) begin errors++; $display("FAIL rerun_mask got %h want %h", matrix_output, MASK_PEAK); end
    $display("reset_midrun rerun cycles=%0d mask=%h", cyc, matrix_output);
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_plateau();
    test_plateau_dominated();
    test_constant();
    test_corners();
    test_busy_write();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
